// File: rtl/fifo_wr_sched.sv
// Round-robin 4-channel sample packer: four 16-bit lanes per 64-bit FIFO word, flushable.
// Latency: word completing in cycle N is written in N+1; fifo_full stalls in WRITE with no grants.
module fifo_wr_sched #(
  parameter logic [15:0] PAD = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        flush,
  input  logic [3:0]  req_valid,
  input  logic [47:0] req_data,
  output logic [3:0]  req_ready,
  output logic [63:0] fifo_din,
  output logic        fifo_wr_en,
  input  logic        fifo_full,
  output logic [15:0] word_cnt
);

  typedef enum logic {
    FILL  = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [1:0]        lane_idx;
  logic [1:0]        rr_last;
  logic [2:0][15:0]  lane_buf;
  logic [3:0][11:0]  req_samp;
  logic [1:0]        gnt_ch;
  logic [1:0]        cand;
  logic              gnt_any;
  logic              xfer;
  logic              flush_act;
  logic              word_done;
  logic [15:0]       lane_new;
  logic [3:0][15:0]  din_nxt;

  assign req_samp = req_data;

  // Round-robin search starts one past the last granted channel; flush beats arbitration.
  always_comb begin
    gnt_any   = 1'b0;
    gnt_ch    = 2'd0;
    cand      = 2'd0;
    req_ready = 4'b0000;
    if (rst && state == FILL && en && !flush) begin
      for (int i = 1; i <= 4; i++) begin
        cand = rr_last + i[1:0];
        if (!gnt_any && req_valid[cand]) begin
          gnt_any = 1'b1;
          gnt_ch  = cand;
        end
      end
      if (gnt_any) begin
        req_ready = 4'b0001 << gnt_ch;
      end
    end
  end

  assign xfer       = |(req_valid & req_ready);
  assign flush_act  = (state == FILL) && flush && (lane_idx != 2'd0);
  assign word_done  = xfer && (lane_idx == 2'd3);
  assign lane_new   = {2'b00, gnt_ch, req_samp[gnt_ch]};
  assign fifo_wr_en = (state == WRITE) && !fifo_full;

  always_comb begin
    din_nxt = fifo_din;
    if (flush_act) begin
      for (int k = 0; k < 3; k++) begin
        din_nxt[k] = (lane_idx > k[1:0]) ? lane_buf[k] : PAD;
      end
      din_nxt[3] = PAD;
    end else if (word_done) begin
      din_nxt = {lane_new, lane_buf[2], lane_buf[1], lane_buf[0]};
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (flush_act || word_done) state_nxt = WRITE;
      WRITE:   if (!fifo_full) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // rr_last resets to 3 so channel 0 is searched first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane_idx <= 2'd0;
      rr_last  <= 2'd3;
      lane_buf <= '0;
      fifo_din <= '0;
      word_cnt <= 16'd0;
    end else begin
      if (flush_act) begin
        lane_idx <= 2'd0;
      end else if (xfer) begin
        case (lane_idx)
          2'd0:    lane_buf[0] <= lane_new;
          2'd1:    lane_buf[1] <= lane_new;
          2'd2:    lane_buf[2] <= lane_new;
          default: ;
        endcase
        lane_idx <= lane_idx + 2'd1;
        rr_last  <= gnt_ch;
      end
      if (flush_act || word_done) begin
        fifo_din <= din_nxt;
      end
      if (fifo_wr_en) begin
        word_cnt <= word_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_sched.sv
// Directed bench for fifo_wr_sched: arbitration order, packing, backpressure, flush, reset, counter wrap.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_fifo_wr_sched;

  logic        clk;
  logic        rst;
  logic        en;
  logic        flush;
  logic [3:0]  req_valid;
  logic [47:0] req_data;
  logic [3:0]  req_ready;
  logic [63:0] fifo_din;
  logic        fifo_wr_en;
  logic        fifo_full;
  logic [15:0] word_cnt;

  int n_run  = 0;
  int n_fail = 0;

  fifo_wr_sched #(.PAD(16'hFFFF)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_din   (fifo_din),
    .fifo_wr_en (fifo_wr_en),
    .fifo_full  (fifo_full),
    .word_cnt   (word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    rst       = 1'b0;
    en        = 1'b1;
    flush     = 1'b0;
    fifo_full = 1'b0;
    req_valid = 4'hF;
    req_data  = {12'h103, 12'h102, 12'h101, 12'h100};
    #2;
    check("rst_ready", 64'(req_ready), 64'h0);
    check("rst_wr_en", 64'(fifo_wr_en), 64'h0);
    check("rst_din", fifo_din, 64'h0);
    check("rst_cnt", 64'(word_cnt), 64'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // All four channels valid: grants 0,1,2,3 then one write.
    for (int k = 0; k < 4; k++) begin
      #1;
      check("rr_all_grant", 64'(req_ready), 64'(4'b0001 << k));
      @(negedge clk);
    end
    req_valid = 4'h0;
    #1;
    check("all_wr_en", 64'(fifo_wr_en), 64'h1);
    check("all_din", fifo_din, 64'h3103_2102_1101_0100);
    check("all_ready_in_write", 64'(req_ready), 64'h0);
    @(negedge clk);
    #1;
    check("all_cnt", 64'(word_cnt), 64'd1);
    check("all_wr_en_off", 64'(fifo_wr_en), 64'h0);

    // Channel 2 only; the word completes while the FIFO is full for 5 cycles.
    req_valid = 4'b0100;
    req_data  = {12'h000, 12'hABC, 12'h000, 12'h000};
    for (int k = 0; k < 4; k++) begin
      if (k == 3) fifo_full = 1'b1;
      #1;
      check("ch2_grant", 64'(req_ready), 64'h4);
      @(negedge clk);
    end
    for (int k = 0; k < 5; k++) begin
      #1;
      check("full_wr_en", 64'(fifo_wr_en), 64'h0);
      check("full_ready", 64'(req_ready), 64'h0);
      check("full_din_hold", fifo_din, 64'h2ABC_2ABC_2ABC_2ABC);
      @(negedge clk);
    end
    fifo_full = 1'b0;
    req_valid = 4'h0;
    #1;
    check("unfull_wr_en", 64'(fifo_wr_en), 64'h1);
    check("unfull_din", fifo_din, 64'h2ABC_2ABC_2ABC_2ABC);
    @(negedge clk);
    #1;
    check("ch2_cnt", 64'(word_cnt), 64'd2);

    // Two samples (ch3 then ch0, pointer last at 2), then flush pads lanes 2 and 3.
    req_valid = 4'b1001;
    req_data  = {12'h044, 12'h033, 12'h022, 12'h011};
    #1;
    check("fl_grant_ch3", 64'(req_ready), 64'h8);
    @(negedge clk);
    #1;
    check("fl_grant_ch0", 64'(req_ready), 64'h1);
    @(negedge clk);
    flush = 1'b1;
    #1;
    check("fl_blocks_grant", 64'(req_ready), 64'h0);
    @(negedge clk);
    flush     = 1'b0;
    req_valid = 4'h0;
    #1;
    check("fl_wr_en", 64'(fifo_wr_en), 64'h1);
    check("fl_din", fifo_din, 64'hFFFF_FFFF_0011_3044);
    @(negedge clk);
    flush = 1'b1;
    #1;
    check("fl_cnt", 64'(word_cnt), 64'd3);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("fl_empty_no_write", 64'(fifo_wr_en), 64'h0);
    @(negedge clk);
    #1;
    check("fl_empty_cnt", 64'(word_cnt), 64'd3);

    // en=0 blocks grants and keeps the pointer; then two transfers before an async reset.
    en        = 1'b0;
    req_valid = 4'hF;
    req_data  = {12'h0DD, 12'h0CC, 12'h0BB, 12'h0AA};
    #1;
    check("en0_ready", 64'(req_ready), 64'h0);
    @(negedge clk);
    en = 1'b1;
    #1;
    check("en1_grant_ch1", 64'(req_ready), 64'h2);
    @(negedge clk);
    #1;
    check("en1_grant_ch2", 64'(req_ready), 64'h4);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("arst_ready", 64'(req_ready), 64'h0);
    check("arst_wr_en", 64'(fifo_wr_en), 64'h0);
    check("arst_din", fifo_din, 64'h0);
    check("arst_cnt", 64'(word_cnt), 64'h0);
    @(negedge clk);
    @(negedge clk);
    rst      = 1'b1;
    req_data = {12'h203, 12'h202, 12'h201, 12'h200};
    for (int k = 0; k < 4; k++) begin
      #1;
      check("post_rst_grant", 64'(req_ready), 64'(4'b0001 << k));
      @(negedge clk);
    end
    req_valid = 4'h0;
    #1;
    check("post_rst_wr_en", 64'(fifo_wr_en), 64'h1);
    check("post_rst_din", fifo_din, 64'h3203_2202_1201_0200);
    @(negedge clk);
    #1;
    check("post_rst_cnt", 64'(word_cnt), 64'd1);

    // Preload the counter instead of spending 65534 words, then two writes across the wrap.
    force dut.word_cnt = 16'hFFFE;
    #1;
    release dut.word_cnt;
    req_data = {12'h000, 12'h000, 12'h000, 12'h055};
    for (int w = 0; w < 2; w++) begin
      @(negedge clk);
      req_valid = 4'b0001;
      #1;
      check("wrap_grant", 64'(req_ready), 64'h1);
      @(negedge clk);
      req_valid = 4'h0;
      flush     = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      #1;
      check("wrap_din", fifo_din, 64'hFFFF_FFFF_FFFF_0055);
      @(negedge clk);
      #1;
      check("wrap_cnt", 64'(word_cnt), (w == 0) ? 64'hFFFF : 64'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_sched.md
FIFO_WR_SCHED -- requirements
Module: fifo_wr_sched

Interface
REQ-001 Parameter: PAD, 16'hFFFF, lane value inserted for unfilled lanes on flush.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 en  input  1  1 = arbitration enabled; 0 = no grants issued.
REQ-005 flush  input  1  single-cycle request to close a partial word.
REQ-006 req_valid  input  4  per-channel sample valid, channel i = bit i.
REQ-007 req_data  input  48  channel i sample at [12i+11:12i], unsigned 12-bit.
REQ-008 req_ready  output  4  one-hot grant; a transfer occurs when req_valid[i] & req_ready[i].
REQ-009 fifo_din  output  64  packed word to the FIFO write port.
REQ-010 fifo_wr_en  output  1  FIFO write strobe, one cycle per word.
REQ-011 fifo_full  input  1  FIFO full flag, same clock domain.
REQ-012 word_cnt  output  16  count of words written since reset.

Function
REQ-013 Two states: FILL (collecting samples), WRITE (word complete, awaiting FIFO space).
REQ-014 Lane format: 16 bits = {2'b00, ch[1:0], sample[11:0]}; lane k at fifo_din[16k+15:16k]; the first sample of a word goes to lane 0.
REQ-015 lane_idx (0..3) selects the next lane to fill; it increments on each transfer.
REQ-016 In FILL with en=1 and flush=0: at most one grant per cycle, round-robin; search starts at (last granted channel + 1) mod 4; req_ready is combinational from req_valid and the pointer.
REQ-017 The round-robin pointer updates only on a transfer.
REQ-018 req_ready is all-zero in WRITE, when en=0, or when flush=1.
REQ-019 A transfer with lane_idx=3 moves the block to WRITE and resets lane_idx to 0.
REQ-020 In WRITE: fifo_wr_en = !fifo_full, combinational; fifo_wr_en shall never be 1 while fifo_full=1.
REQ-021 When a write occurs, the block returns to FILL on the next edge.
REQ-022 If fifo_full=1, the block holds WRITE with fifo_din stable; no samples are lost.
REQ-023 Latency: 4th transfer in cycle N -> fifo_wr_en=1 in cycle N+1 when fifo_full=0.
REQ-024 Flush in FILL with lane_idx>0: lanes lane_idx..3 take PAD; the block moves to WRITE. No grant occurs that cycle (flush wins over arbitration).
REQ-025 Flush in FILL with lane_idx=0, or in WRITE, is ignored.
REQ-026 en=0 holds the partial word, lane_idx and pointer unchanged; flush still acts per REQ-024.
REQ-027 word_cnt increments on each fifo_wr_en=1 cycle and wraps from 16'hFFFF to 0.
REQ-028 fifo_din holds its last value outside WRITE.

Reset
REQ-029 On rst=0 (asynchronous), the following take their reset values:
- state = FILL, lane_idx = 0
- round-robin pointer: channel 0 has highest priority
- fifo_din = 0, word_cnt = 0
REQ-030 While rst=0: fifo_wr_en = 0 and req_ready = 0 regardless of inputs.
REQ-031 Reset mid-word discards the partial word; nothing is written.

Verification
REQ-032 All four channels continuously valid with data 12'h100+i, fifo_full=0 -> grants 0,1,2,3 in four cycles; next cycle fifo_wr_en=1, fifo_din=64'h3103_2102_1101_0100; word_cnt=1.
REQ-033 Only channel 2 valid, data 12'hABC -> four consecutive grants to channel 2; fifo_din=64'h2ABC_2ABC_2ABC_2ABC.
REQ-034 Word completes while fifo_full=1 for 5 cycles:
- fifo_wr_en=0 and req_ready=0 for those 5 cycles
- write occurs on the first cycle fifo_full=0, with unchanged din
REQ-035 Two samples taken, then flush pulse:
- next cycle, lanes 2,3 = 16'hFFFF and fifo_wr_en=1
- flush with lane_idx=0 -> no write.
REQ-036 rst driven low asynchronously after 2 transfers -> outputs zero immediately; after release, the first grant goes to channel 0 and the first write holds only post-reset samples.
REQ-037 Preload word_cnt to 16'hFFFF by 65535 writes, then one more write -> word_cnt=0.
